// File: rtl/mul_sched_pkg.sv
// rtl/mul_sched_pkg.sv - shared modes, states and defaults for the multiplier scheduler
package mul_sched_pkg;

    // Multiplier cm_i encodings
    localparam logic [1:0] MODE_SINGLE8 = 2'b00;
    localparam logic [1:0] MODE_PAR8    = 2'b01;
    localparam logic [1:0] MODE_MUL16   = 2'b10;
    localparam logic [1:0] MODE_RSVD    = 2'b11;

    // Default number of WAIT cycles before an operation is aborted
    localparam int TIMEOUT_DEFAULT = 64;

    // Scheduler sequencing states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } sched_state_e;

    // True when a mode value cannot be issued to the multiplier
    function automatic logic is_reserved(input logic [1:0] mode);
        return mode == MODE_RSVD;
    endfunction

endpackage

// File: rtl/mul_scheduler_rr_arbiter2.sv
// rtl/mul_scheduler_rr_arbiter2.sv - two-input round-robin arbiter with accept-driven pointer
module rr_arbiter2 (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] grant_o,
    output logic       grant_id_o
);

    // ptr_q names the requester that wins a tie; it moves away from whoever was last served
    logic ptr_q;
    logic ptr_d;

    // Grant the favoured requester if it asks, otherwise the other one
    always_comb begin
        grant_id_o = ptr_q;
        grant_o    = 2'b00;
        ptr_d      = ptr_q;
        if (!req_i[ptr_q]) begin
            grant_id_o = ~ptr_q;
        end
        if (|req_i) begin
            grant_o[grant_id_o] = 1'b1;
        end
        if (accept_i) begin
            ptr_d = ~grant_id_o;
        end
    end

    // Pointer register; reset favours requester 0
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mul_scheduler.sv
// rtl/mul_scheduler.sv - round-robin sequencer sharing one multiplier between two requesters
module mul_scheduler
    import mul_sched_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int CNT_W          = 7
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [1:0]            req_valid_i,
    output logic [1:0]            req_ready_o,
    input  logic [2*DATA_W-1:0]   req_a_i,
    input  logic [2*DATA_W-1:0]   req_b_i,
    input  logic [3:0]            req_mode_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic                  rsp_id_o,
    output logic [2*DATA_W-1:0]   rsp_data_o,
    output logic                  rsp_err_o,
    output logic [DATA_W-1:0]     mul_a_o,
    output logic [DATA_W-1:0]     mul_b_o,
    output logic [1:0]            mul_cm_o,
    output logic                  mul_enable_o,
    output logic                  mul_reset_no,
    input  logic [2*DATA_W-1:0]   mul_product_i,
    input  logic                  mul_data_valid_i,
    output logic                  busy_o
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    sched_state_e state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [1:0]          cm_q, cm_d;
    logic                id_q, id_d;
    logic [2*DATA_W-1:0] data_q, data_d;
    logic                err_q, err_d;
    logic                enable_q, enable_d;
    logic                reset_n_q, reset_n_d;

    logic [1:0]          grant;
    logic                grant_id;
    logic                accept;
    logic [DATA_W-1:0]   sel_a;
    logic [DATA_W-1:0]   sel_b;
    logic [1:0]          sel_mode;

    rr_arbiter2 u_arb (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .req_i      (req_valid_i),
        .accept_i   (accept),
        .grant_o    (grant),
        .grant_id_o (grant_id)
    );

    // Requests are only offered in IDLE; the arbiter grants only valid requesters
    always_comb begin
        req_ready_o = (state_q == IDLE) ? grant : 2'b00;
        accept      = (state_q == IDLE) && (|grant);
        sel_a       = grant_id ? req_a_i[DATA_W +: DATA_W] : req_a_i[0 +: DATA_W];
        sel_b       = grant_id ? req_b_i[DATA_W +: DATA_W] : req_b_i[0 +: DATA_W];
        sel_mode    = grant_id ? req_mode_i[3:2] : req_mode_i[1:0];
    end

    // Sequencing: accept, clear multiplier, start it, wait for product or timeout, respond
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        cm_d    = cm_q;
        id_d    = id_q;
        data_d  = data_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d  = sel_a;
                    b_d  = sel_b;
                    cm_d = sel_mode;
                    id_d = grant_id;
                    if (is_reserved(sel_mode)) begin
                        err_d   = 1'b1;
                        data_d  = '0;
                        state_d = RESP;
                    end else begin
                        state_d = CLEAR;
                    end
                end
            end
            CLEAR: begin
                state_d = START;
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A product arriving on the final WAIT cycle still beats the timeout
                if (mul_data_valid_i) begin
                    data_d  = mul_product_i;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == TMO_LAST) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Multiplier controls are registered so they line up with the state they belong to
        enable_d  = (state_d == START);
        reset_n_d = (state_d != CLEAR);
    end

    // State and datapath registers; reset holds the multiplier in reset
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            cm_q      <= '0;
            id_q      <= 1'b0;
            data_q    <= '0;
            err_q     <= 1'b0;
            enable_q  <= 1'b0;
            reset_n_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cm_q      <= cm_d;
            id_q      <= id_d;
            data_q    <= data_d;
            err_q     <= err_d;
            enable_q  <= enable_d;
            reset_n_q <= reset_n_d;
        end
    end

    // Output mapping
    always_comb begin
        rsp_valid_o  = (state_q == RESP);
        busy_o       = (state_q != IDLE);
        rsp_id_o     = id_q;
        rsp_data_o   = data_q;
        rsp_err_o    = err_q;
        mul_a_o      = a_q;
        mul_b_o      = b_q;
        mul_cm_o     = cm_q;
        mul_enable_o = enable_q;
        mul_reset_no = reset_n_q;
    end

endmodule
